// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM lane mux/demux family: lane count, slot type and slot bounds.
// Lane k of a parallel word always lives at bits [k*WIDTH +: WIDTH].
package tdm_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_FIRST = 2'd0;
    localparam slot_t SLOT_LAST  = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit wrapping slot counter with realign; shared by the TDM serialiser and deserialiser.
// sync forces the current beat (if any) to be slot 0, so the next slot is 1 (or 0 with no beat).
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              sync,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (sync) begin
            slot_d = advance ? SLOT_FIRST + slot_t'(1) : SLOT_FIRST;
        end else if (advance) begin
            slot_d = slot_q + slot_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_FIRST;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux1to4.sv
// Time-division 1-to-4 demultiplexer: beats are steered into lanes 0..3 by the slot counter and
// the completed word is presented with a valid/ready handshake.
module tdm_demux1to4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sync,
    output logic [LANES*WIDTH-1:0] o,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [SLOT_W-1:0]      s
);

    logic [WIDTH-1:0]       shadow_q [LANES-1];
    logic [LANES*WIDTH-1:0] o_q;
    logic [LANES*WIDTH-1:0] frame;
    logic                   o_valid_q;
    logic [SLOT_W-1:0]      slot;
    logic                   slot_last;
    logic                   accept;
    logic                   frame_done;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
        .sync    (sync),
        .slot    (slot),
        .last    (slot_last)
    );

    // Only the lane-3 beat needs room on the output side.
    assign in_ready   = !slot_last || !o_valid_q || o_ready;
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && !sync && slot_last;

    always_comb begin
        frame = '0;
        for (int k = 0; k < LANES - 1; k++) begin
            frame[k*WIDTH +: WIDTH] = shadow_q[k];
        end
        frame[(LANES-1)*WIDTH +: WIDTH] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES - 1; k++) begin
                shadow_q[k] <= '0;
            end
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            if (sync) begin
                // Realign: drop the partial frame; an accepted beat becomes lane 0.
                for (int k = 0; k < LANES - 1; k++) begin
                    shadow_q[k] <= '0;
                end
                if (accept) begin
                    shadow_q[0] <= d;
                end
            end else if (accept && !slot_last) begin
                for (int k = 0; k < LANES - 1; k++) begin
                    if (slot == slot_t'(k)) begin
                        shadow_q[k] <= d;
                    end
                end
            end

            if (frame_done) begin
                o_q       <= frame;
                o_valid_q <= 1'b1;
            end else if (o_valid_q && o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign s       = slot;

endmodule
